addsub_serial_unit: RTL and testbench

- Multi-cycle, parametrised two's-complement adder/subtractor.
- Processes DIGIT bits per clock through a DIGIT-bit ripple slice, LSB first, and reports status flags.
- Trades area for latency against the flat 8-bit ripple add/sub datapath.
- Sits in the ALU datapath behind a start/busy/done handshake with the sequencer.

---
 rtl/addsub_serial_unit.sv | 157 +++++++++++++++
 tb/tb_addsub_serial_unit.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_serial_unit.sv
// addsub_serial_unit: digit-serial two's-complement adder/subtractor.
// Operands are latched on accept, then DIGIT bits per clock are summed LSB
// first through a DIGIT-bit ripple slice. Result and flags update together
// on the final compute edge; done pulses for one cycle afterwards.
// WIDTH must be a multiple of DIGIT and at least 2.
module addsub_serial_unit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_acc;
   logic             r_mode;
   logic             r_carry;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic [DIGIT-1:0] w_a_slice;
   logic [DIGIT-1:0] w_b_slice;
   logic [DIGIT-1:0] w_sum;
   logic [DIGIT:0]   w_c;
   logic [WIDTH-1:0] w_acc_next;

   // The digit currently being processed is selected by the counter; the
   // subtract inversion is applied here so the slice adder is mode-agnostic.
   assign w_last    = (r_cnt == CW'(N - 1));
   assign w_a_slice = r_a[r_cnt*DIGIT +: DIGIT];
   assign w_b_slice = r_b[r_cnt*DIGIT +: DIGIT] ^ {DIGIT{r_mode}};
   assign w_c[0]    = r_carry;

   // DIGIT-bit ripple slice; w_c[DIGIT-1] is the carry into the slice MSB,
   // which on the final digit is the carry into bit WIDTH-1.
   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      assign w_sum[gi]   = w_a_slice[gi] ^ w_b_slice[gi] ^ w_c[gi];
      assign w_c[gi+1]   = (w_a_slice[gi] & w_b_slice[gi]) |
                           (w_a_slice[gi] & w_c[gi])       |
                           (w_b_slice[gi] & w_c[gi]);
   end

   // Accumulator with the current sum slice merged in at the active digit.
   always_comb begin
      w_acc_next                        = r_acc;
      w_acc_next[r_cnt*DIGIT +: DIGIT]  = w_sum;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic and handshake outputs (decoded from state only).
   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      w_accept     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            done = 1'b1;
            if (start) begin
               w_accept     = 1'b1;
               w_state_next = S_RUN;
            end else begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Operand latch, digit counter, running carry and partial accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_mode  <= 1'b0;
         r_carry <= 1'b0;
         r_cnt   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_mode  <= mode;
         r_carry <= mode;
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_acc   <= w_acc_next;
         r_carry <= w_c[DIGIT];
         r_cnt   <= r_cnt + CW'(1);
      end
   end

   // Visible result and flags change only on the final digit, so a partial
   // sum is never exposed.
   always_ff @(posedge clk) begin
      if (rst) begin
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         zero      <= 1'b0;
         negative  <= 1'b0;
      end else if ((r_state == S_RUN) && w_last) begin
         result    <= w_acc_next;
         carry_out <= w_c[DIGIT];
         overflow  <= w_c[DIGIT] ^ w_c[DIGIT-1];
         zero      <= (w_acc_next == '0);
         negative  <= w_acc_next[WIDTH-1];
      end
   end

endmodule

// File: tb/tb_addsub_serial_unit.sv
// Testbench for addsub_serial_unit: directed and random operations on an
// 8-bit/DIGIT=1 instance plus 16-bit instances for DIGIT 1, 2, 4, 8.
// Expected results are queued on accept and checked by monitors on done.
module tb_addsub_serial_unit;

   logic       clk;
   logic       rst;
   logic       start;
   logic       mode;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] result;
   logic       carry_out;
   logic       overflow;
   logic       zero;
   logic       negative;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [15:0] r;
      logic [3:0]  f;   // {carry_out, overflow, zero, negative}
   } exp_t;

   exp_t q_main[$];
   bit   sweep_go = 1'b0;
   bit   sweep_fin[4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   addsub_serial_unit #(.WIDTH(8), .DIGIT(1)) u_dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .carry_out(carry_out),
      .overflow(overflow), .zero(zero), .negative(negative)
   );

   // Reference: plain integer arithmetic on w-bit operands.
   function automatic exp_t ref_model(input int w, input logic m,
                                      input logic [15:0] x, input logic [15:0] y);
      longint mask, xa, ya, s;
      exp_t   e;
      logic   sa, sb, sr, c, v;
      mask = (longint'(1) << w) - 1;
      xa   = longint'(x) & mask;
      ya   = longint'(y) & mask;
      if (m) s = xa + ((~ya) & mask) + 1;
      else   s = xa + ya;
      e.r = 16'(s & mask);
      c   = ((s >> w) & 1) != 0;
      sa  = x[w-1];
      sb  = y[w-1];
      sr  = e.r[w-1];
      if (m) v = (sa != sb) && (sr != sa);
      else   v = (sa == sb) && (sr != sa);
      e.f = {c, v, (e.r == 16'h0), sr};
      return e;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   // Called with busy = 0 (IDLE or DONE cycle), #1 after a rising edge.
   task automatic issue(input logic m, input logic [7:0] x, input logic [7:0] y);
      start = 1'b1; mode = m; a = x; b = y;
      @(posedge clk);
      q_main.push_back(ref_model(8, m, {8'h00, x}, {8'h00, y}));
      #1;
      start = 1'b0; mode = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      chk("main_busy_after_accept", 16'(busy), 16'h1);
   endtask

   task automatic wait_done(output int n);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!done && n < 200);
      if (!done) begin
         n_vec++; n_err++;
         $display("FAIL main_done_timeout: got no done after %0d cycles, expected done", n);
      end
   endtask

   task automatic chk_out(input string nm, input logic [7:0] r, input logic [3:0] f);
      chk({nm, "_result"}, {8'h00, result}, {8'h00, r});
      chk({nm, "_flags"}, {12'h000, carry_out, overflow, zero, negative}, {12'h000, f});
   endtask

   // Scoreboard monitor for the 8-bit instance.
   always @(negedge clk) begin
      if (done) begin
         if (q_main.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL main_spurious_done: got done=1, expected no pending operation");
         end else begin
            exp_t e;
            e = q_main.pop_front();
            $display("main txn result=%h cvzn=%b", result, {carry_out, overflow, zero, negative});
            chk("main_sb_result", {8'h00, result}, e.r);
            chk("main_sb_flags", {12'h000, carry_out, overflow, zero, negative}, {12'h000, e.f});
            chk("main_sb_busy_low", 16'(busy), 16'h0);
         end
      end
   end

   // 16-bit instances across digit sizes, each with its own scoreboard.
   for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
      localparam int D  = 1 << gi;
      localparam int NN = 16 / D;

      logic        s_start, s_mode, s_busy, s_done, s_c, s_v, s_z, s_n;
      logic [15:0] s_a, s_b, s_res;
      exp_t        q[$];

      addsub_serial_unit #(.WIDTH(16), .DIGIT(D)) u_dut (
         .clk(clk), .rst(rst), .start(s_start), .mode(s_mode), .a(s_a), .b(s_b),
         .busy(s_busy), .done(s_done), .result(s_res), .carry_out(s_c),
         .overflow(s_v), .zero(s_z), .negative(s_n)
      );

      always @(negedge clk) begin
         if (s_done) begin
            if (q.size() == 0) begin
               n_vec++; n_err++;
               $display("FAIL sweep_d%0d_spurious_done: got done=1, expected no pending operation", D);
            end else begin
               exp_t e;
               e = q.pop_front();
               $display("sweep_d%0d txn result=%h cvzn=%b", D, s_res, {s_c, s_v, s_z, s_n});
               chk($sformatf("sweep_d%0d_result", D), s_res, e.r);
               chk($sformatf("sweep_d%0d_flags", D), {12'h000, s_c, s_v, s_z, s_n}, {12'h000, e.f});
            end
         end
      end

      initial begin
         int          n;
         logic        m;
         logic [15:0] x, y;
         s_start = 1'b0; s_mode = 1'b0; s_a = '0; s_b = '0;
         sweep_fin[gi] = 1'b0;
         wait (sweep_go);
         @(posedge clk); #1;
         for (int i = 0; i < 25; i++) begin
            if (i == 0) begin
               m = 1'b1; x = 16'h1234; y = 16'h0235;
            end else begin
               m = 1'($urandom); x = 16'($urandom); y = 16'($urandom);
               case ($urandom_range(0, 5))
                  0: y = x;
                  1: y = 16'hFFFF;
                  2: x = 16'h8000;
                  default: ;
               endcase
            end
            s_start = 1'b1; s_mode = m; s_a = x; s_b = y;
            @(posedge clk);
            q.push_back(ref_model(16, m, x, y));
            #1;
            s_start = 1'b0; s_a = 16'($urandom); s_b = 16'($urandom); s_mode = 1'($urandom);
            n = 0;
            do begin
               @(posedge clk); #1; n++;
            end while (!s_done && n < 100);
            chk($sformatf("sweep_d%0d_latency", D), 16'(n), 16'(NN));
            if (i == 0) begin
               chk($sformatf("sweep_d%0d_1234m0235", D), s_res, 16'h0FFF);
               chk($sformatf("sweep_d%0d_1234m0235_cv", D), {14'h0, s_c, s_v}, 16'h0002);
            end
            if ($urandom_range(0, 1) == 1) begin
               @(posedge clk); #1;
            end
         end
         @(posedge clk); #1;
         chk($sformatf("sweep_d%0d_queue_empty", D), 16'(q.size()), 16'h0);
         sweep_fin[gi] = 1'b1;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no completion, expected summary before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int seen;
      int gap;
      rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk_out("rst", 8'h00, 4'b0000);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed arithmetic cases.
      issue(1'b1, 8'h05, 8'h03); wait_done(n);
      chk("main_latency", 16'(n), 16'd8);
      chk_out("sub_05_03", 8'h02, 4'b1000);
      @(posedge clk); #1;
      chk("done_single_cycle", 16'(done), 16'h0);
      chk("idle_not_busy", 16'(busy), 16'h0);
      issue(1'b1, 8'h03, 8'h05); wait_done(n); chk_out("sub_03_05", 8'hFE, 4'b0001);
      issue(1'b1, 8'h80, 8'h01); wait_done(n); chk_out("sub_80_01", 8'h7F, 4'b1100);
      issue(1'b0, 8'h7F, 8'h01); wait_done(n); chk_out("add_7f_01", 8'h80, 4'b0101);
      issue(1'b0, 8'hFF, 8'h01); wait_done(n); chk_out("add_ff_01", 8'h00, 4'b1010);

      // Start while busy is ignored; back-to-back start in the DONE cycle.
      issue(1'b0, 8'h10, 8'h20);
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1; mode = 1'b1; a = 8'hFF; b = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0; a = 8'h55; b = 8'h66;
      wait_done(n);
      chk("ignore_latency", 16'(n), 16'd5);
      chk_out("ignore_busy_start", 8'h30, 4'b0000);
      issue(1'b1, 8'h09, 8'h04); wait_done(n);
      chk("b2b_latency", 16'(n), 16'd8);
      chk_out("b2b", 8'h05, 4'b1000);

      // Reset in the middle of RUN aborts with no done pulse.
      @(posedge clk); #1;
      issue(1'b0, 8'h12, 8'h34);
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      q_main.delete();
      @(posedge clk); #1;
      chk("abort_busy", 16'(busy), 16'h0);
      chk("abort_done", 16'(done), 16'h0);
      chk_out("abort", 8'h00, 4'b0000);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (done) seen++;
      end
      chk("abort_no_done", 16'(seen), 16'h0);
      issue(1'b0, 8'h21, 8'h13); wait_done(n);
      chk_out("after_abort", 8'h34, 4'b0000);

      // Random traffic on the 8-bit instance alongside the digit sweep.
      sweep_go = 1'b1;
      for (int i = 0; i < 40; i++) begin
         gap = $urandom_range(0, 2);
         repeat (gap) begin @(posedge clk); #1; end
         issue(1'($urandom), 8'($urandom), 8'($urandom));
         wait_done(n);
         chk("rand_latency", 16'(n), 16'd8);
      end

      n = 0;
      while (!(sweep_fin[0] && sweep_fin[1] && sweep_fin[2] && sweep_fin[3]) && n < 5000) begin
         @(posedge clk); n++;
      end
      chk("sweep_completed", 16'(n < 5000), 16'h1);
      @(posedge clk); #1;
      chk("main_queue_empty", 16'(q_main.size()), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
